// File: rtl/pong_frame_engine.sv
// Pong game core: paddles, ball physics, score/serve FSM and a registered per-pixel
// overlay. Game state advances once per frame, on the rising edge of the VS level.
module pong_frame_engine #(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int PAD_W       = 10,
    parameter int PAD_H       = 40,
    parameter int PAD_L_X     = 20,
    parameter int PAD_R_X     = 610,
    parameter int PAD_MARGIN  = 10,
    parameter int PAD_SPEED   = 3,
    parameter int BALL_SIZE   = 8,
    parameter int BALL_SPEED  = 2,
    parameter int WIN_SCORE   = 9,
    parameter int SCORE_W     = 4,
    parameter int HOLD_FRAMES = 60
) (
    input  logic               iVGA_CLK,
    input  logic               iRST_n,
    input  logic               iVS,
    input  logic               iBLANK_n,
    input  logic [9:0]         iX,
    input  logic [9:0]         iY,
    input  logic [1:0]         iUP,
    input  logic [1:0]         iDN,
    input  logic               iSERVE,
    output logic               oOVL,
    output logic [7:0]         oR,
    output logic [7:0]         oG,
    output logic [7:0]         oB,
    output logic [SCORE_W-1:0] oSCORE_L,
    output logic [SCORE_W-1:0] oSCORE_R,
    output logic [1:0]         oSTATE,
    output logic               oFRAME_TICK
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_POINT = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    typedef logic signed [10:0] coord_t;

    localparam int PAD_MIN = PAD_MARGIN;
    localparam int PAD_MAX = V_RES - PAD_MARGIN - PAD_H;
    localparam int PAD_Y0  = (V_RES - PAD_H) / 2;
    localparam int BALL_X0 = (H_RES - BALL_SIZE) / 2;
    localparam int BALL_Y0 = (V_RES - BALL_SIZE) / 2;
    localparam int L_FACE  = PAD_L_X + PAD_W;
    localparam int HOLD_W  = $clog2(HOLD_FRAMES + 1);
    localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

    logic               vs_q;
    logic               tick;
    state_t             state, state_nxt;
    logic [9:0]         pad_l_y, pad_r_y, pad_l_nxt, pad_r_nxt;
    coord_t             ball_x, ball_y, vx, vy;
    coord_t             ball_x_nxt, ball_y_nxt, vx_nxt, vy_nxt;
    logic [SCORE_W-1:0] score_l, score_r, score_l_nxt, score_r_nxt;
    logic [HOLD_W-1:0]  hold, hold_nxt;
    logic               ovl_nxt;
    logic [23:0]        rgb_nxt;

    // vs_q resets high so a VS level already high out of reset is not taken as a tick.
    assign tick        = iVS & ~vs_q;
    assign oFRAME_TICK = tick;
    assign oSTATE      = state;
    assign oSCORE_L    = score_l;
    assign oSCORE_R    = score_r;

    function automatic logic [9:0] pad_step(input logic [9:0] y, input logic up, input logic dn);
        int t;
        t = int'(y);
        if (up && !dn)
            t = t - PAD_SPEED;
        else if (dn && !up)
            t = t + PAD_SPEED;
        if (t < PAD_MIN)
            t = PAD_MIN;
        if (t > PAD_MAX)
            t = PAD_MAX;
        return 10'(t);
    endfunction

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (s >= WIN) ? s : s + SCORE_W'(1);
    endfunction

    always_comb begin
        int   bx, by, nx, ny, vxa, vya, pl, pr;
        logic hit_l, hit_r;
        // NOTE: every output of this block is defaulted first so no path can infer a latch.
        state_nxt   = state;
        pad_l_nxt   = pad_l_y;
        pad_r_nxt   = pad_r_y;
        ball_x_nxt  = ball_x;
        ball_y_nxt  = ball_y;
        vx_nxt      = vx;
        vy_nxt      = vy;
        score_l_nxt = score_l;
        score_r_nxt = score_r;
        hold_nxt    = hold;

        bx  = int'(ball_x);
        by  = int'(ball_y);
        vxa = vx[10] ? -int'(vx) : int'(vx);
        vya = vy[10] ? -int'(vy) : int'(vy);
        nx  = bx + int'(vx);
        ny  = by + int'(vy);
        pl  = int'(pad_l_y);
        pr  = int'(pad_r_y);
        hit_l = vx[10] && (nx <= L_FACE) && (bx >= L_FACE)
                && (by + BALL_SIZE > pl) && (by < pl + PAD_H);
        hit_r = !vx[10] && (nx + BALL_SIZE >= PAD_R_X) && (bx + BALL_SIZE <= PAD_R_X)
                && (by + BALL_SIZE > pr) && (by < pr + PAD_H);

        if (tick) begin
            pad_l_nxt = pad_step(pad_l_y, iUP[0], iDN[0]);
            pad_r_nxt = pad_step(pad_r_y, iUP[1], iDN[1]);
            case (state)
                ST_IDLE: if (iSERVE) state_nxt = ST_PLAY;
                ST_PLAY: begin
                    if (ny <= 0) begin
                        ball_y_nxt = '0;
                        vy_nxt     = coord_t'(vya);
                    end else if (ny >= V_RES - BALL_SIZE) begin
                        ball_y_nxt = coord_t'(V_RES - BALL_SIZE);
                        vy_nxt     = coord_t'(-vya);
                    end else begin
                        ball_y_nxt = coord_t'(ny);
                    end

                    if (hit_l) begin
                        ball_x_nxt = coord_t'(L_FACE);
                        vx_nxt     = coord_t'(vxa);
                    end else if (hit_r) begin
                        ball_x_nxt = coord_t'(PAD_R_X - BALL_SIZE);
                        vx_nxt     = coord_t'(-vxa);
                    end else if (nx <= 0 || nx >= H_RES - BALL_SIZE) begin
                        // Serve goes back toward the player who conceded.
                        if (nx <= 0) begin
                            score_r_nxt = sat_inc(score_r);
                            vx_nxt      = coord_t'(-vxa);
                        end else begin
                            score_l_nxt = sat_inc(score_l);
                            vx_nxt      = coord_t'(vxa);
                        end
                        ball_x_nxt = coord_t'(BALL_X0);
                        ball_y_nxt = coord_t'(BALL_Y0);
                        if (score_l_nxt == WIN || score_r_nxt == WIN) begin
                            state_nxt = ST_OVER;
                        end else begin
                            state_nxt = ST_POINT;
                            hold_nxt  = HOLD_W'(HOLD_FRAMES);
                        end
                    end else begin
                        ball_x_nxt = coord_t'(nx);
                    end
                end
                ST_POINT: begin
                    if (hold <= HOLD_W'(1)) begin
                        state_nxt = ST_PLAY;
                        hold_nxt  = '0;
                    end else begin
                        hold_nxt = hold - HOLD_W'(1);
                    end
                end
                ST_OVER: begin
                    if (iSERVE) begin
                        state_nxt   = ST_IDLE;
                        score_l_nxt = '0;
                        score_r_nxt = '0;
                        ball_x_nxt  = coord_t'(BALL_X0);
                        ball_y_nxt  = coord_t'(BALL_Y0);
                        vx_nxt      = coord_t'(BALL_SPEED);
                        vy_nxt      = coord_t'(BALL_SPEED);
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            vs_q    <= 1'b1;
            state   <= ST_IDLE;
            pad_l_y <= 10'(PAD_Y0);
            pad_r_y <= 10'(PAD_Y0);
            ball_x  <= coord_t'(BALL_X0);
            ball_y  <= coord_t'(BALL_Y0);
            vx      <= coord_t'(BALL_SPEED);
            vy      <= coord_t'(BALL_SPEED);
            score_l <= '0;
            score_r <= '0;
            hold    <= '0;
        end else begin
            // NOTE: non-blocking updates so every register sees pre-edge values.
            vs_q    <= iVS;
            state   <= state_nxt;
            pad_l_y <= pad_l_nxt;
            pad_r_y <= pad_r_nxt;
            ball_x  <= ball_x_nxt;
            ball_y  <= ball_y_nxt;
            vx      <= vx_nxt;
            vy      <= vy_nxt;
            score_l <= score_l_nxt;
            score_r <= score_r_nxt;
            hold    <= hold_nxt;
        end
    end

    always_comb begin
        int   px, py, bx, by;
        logic hit_ball, hit_pad, hit_line;
        px = int'(iX);
        py = int'(iY);
        bx = int'(ball_x);
        by = int'(ball_y);
        hit_ball = (px >= bx) && (px < bx + BALL_SIZE) && (py >= by) && (py < by + BALL_SIZE);
        hit_pad  = ((px >= PAD_L_X) && (px < PAD_L_X + PAD_W)
                    && (py >= int'(pad_l_y)) && (py < int'(pad_l_y) + PAD_H))
                || ((px >= PAD_R_X) && (px < PAD_R_X + PAD_W)
                    && (py >= int'(pad_r_y)) && (py < int'(pad_r_y) + PAD_H));
        hit_line = ((px == H_RES / 2 - 1) || (px == H_RES / 2)) && !iY[3];
        ovl_nxt  = 1'b0;
        rgb_nxt  = 24'h000000;
        if (iBLANK_n) begin
            if (hit_ball) begin
                ovl_nxt = 1'b1;
                rgb_nxt = 24'hFFFFFF;
            end else if (hit_pad) begin
                ovl_nxt = 1'b1;
                rgb_nxt = 24'h00FF00;
            end else if (hit_line) begin
                ovl_nxt = 1'b1;
                rgb_nxt = 24'h808080;
            end
        end
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            oOVL <= 1'b0;
            oR   <= '0;
            oG   <= '0;
            oB   <= '0;
        end else begin
            oOVL <= ovl_nxt;
            oR   <= rgb_nxt[23:16];
            oG   <= rgb_nxt[15:8];
            oB   <= rgb_nxt[7:0];
        end
    end

endmodule

// File: tb/tb_pong_frame_engine.sv
// Randomized bench for pong_frame_engine: a frame-level game model predicts every
// probed pixel and the score/state registers; a monitor drains the expectation queue.
module tb_pong_frame_engine;

    localparam int H_RES = 640, V_RES = 480, PAD_W = 10, PAD_H = 40;
    localparam int PAD_L_X = 20, PAD_R_X = 610, PAD_MARGIN = 10, PAD_SPEED = 3;
    localparam int BS = 8, SPD = 2, WIN = 9, SCORE_W = 4, HOLD = 60;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               vs = 1'b0;
    logic               blank_n = 1'b0;
    logic [9:0]         x = '0, y = '0;
    logic [1:0]         up = '0, dn = '0;
    logic               serve = 1'b0;
    logic               ovl, tick;
    logic [7:0]         r, g, b;
    logic [SCORE_W-1:0] score_l, score_r;
    logic [1:0]         state;

    pong_frame_engine dut (
        .iVGA_CLK(clk), .iRST_n(rst_n), .iVS(vs), .iBLANK_n(blank_n),
        .iX(x), .iY(y), .iUP(up), .iDN(dn), .iSERVE(serve),
        .oOVL(ovl), .oR(r), .oG(g), .oB(b),
        .oSCORE_L(score_l), .oSCORE_R(score_r), .oSTATE(state), .oFRAME_TICK(tick)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: whole-game state in plain integers, advanced once per frame.
    int m_state, m_pl, m_pr, m_bx, m_by, m_vx, m_vy, m_sl, m_sr, m_hold;

    function automatic int clamp_pad(input int v);
        if (v < PAD_MARGIN) return PAD_MARGIN;
        if (v > V_RES - PAD_MARGIN - PAD_H) return V_RES - PAD_MARGIN - PAD_H;
        return v;
    endfunction

    function automatic int pad_dir(input bit u, input bit d);
        return (u && !d) ? -1 : ((d && !u) ? 1 : 0);
    endfunction

    task automatic model_reset();
        m_state = 0; m_pl = (V_RES - PAD_H) / 2; m_pr = m_pl;
        m_bx = (H_RES - BS) / 2; m_by = (V_RES - BS) / 2;
        m_vx = SPD; m_vy = SPD; m_sl = 0; m_sr = 0; m_hold = 0;
    endtask

    task automatic model_tick(input bit [1:0] u, input bit [1:0] d, input bit s);
        int  old_pl, old_pr, nx, ny;
        bit  on_l, on_r;
        old_pl = m_pl;
        old_pr = m_pr;
        m_pl = clamp_pad(m_pl + PAD_SPEED * pad_dir(u[0], d[0]));
        m_pr = clamp_pad(m_pr + PAD_SPEED * pad_dir(u[1], d[1]));
        case (m_state)
            0: if (s) m_state = 1;
            1: begin
                nx   = m_bx + m_vx;
                ny   = m_by + m_vy;
                on_l = (m_vx < 0) && nx <= PAD_L_X + PAD_W && m_bx >= PAD_L_X + PAD_W
                       && m_by + BS > old_pl && m_by < old_pl + PAD_H;
                on_r = (m_vx > 0) && nx + BS >= PAD_R_X && m_bx + BS <= PAD_R_X
                       && m_by + BS > old_pr && m_by < old_pr + PAD_H;
                if (ny <= 0) begin m_by = 0; m_vy = SPD; end
                else if (ny >= V_RES - BS) begin m_by = V_RES - BS; m_vy = -SPD; end
                else m_by = ny;
                if (on_l) begin m_bx = PAD_L_X + PAD_W; m_vx = SPD; end
                else if (on_r) begin m_bx = PAD_R_X - BS; m_vx = -SPD; end
                else if (nx <= 0 || nx >= H_RES - BS) begin
                    if (nx <= 0) begin
                        if (m_sr < WIN) m_sr++;
                        m_vx = -SPD;
                    end else begin
                        if (m_sl < WIN) m_sl++;
                        m_vx = SPD;
                    end
                    m_bx = (H_RES - BS) / 2;
                    m_by = (V_RES - BS) / 2;
                    if (m_sl == WIN || m_sr == WIN) m_state = 3;
                    else begin m_state = 2; m_hold = HOLD; end
                end else m_bx = nx;
            end
            2: begin
                m_hold--;
                if (m_hold == 0) m_state = 1;
            end
            default: if (s) begin
                m_state = 0; m_sl = 0; m_sr = 0;
                m_bx = (H_RES - BS) / 2; m_by = (V_RES - BS) / 2; m_vx = SPD; m_vy = SPD;
            end
        endcase
    endtask

    function automatic logic [24:0] model_pix(input int px, input int py, input bit bl);
        if (!bl) return 25'h0;
        if (px >= m_bx && px < m_bx + BS && py >= m_by && py < m_by + BS) return {1'b1, 24'hFFFFFF};
        if (px >= PAD_L_X && px < PAD_L_X + PAD_W && py >= m_pl && py < m_pl + PAD_H) return {1'b1, 24'h00FF00};
        if (px >= PAD_R_X && px < PAD_R_X + PAD_W && py >= m_pr && py < m_pr + PAD_H) return {1'b1, 24'h00FF00};
        if ((px == H_RES / 2 - 1 || px == H_RES / 2) && ((py / 8) % 2 == 0)) return {1'b1, 24'h808080};
        return 25'h0;
    endfunction

    typedef struct {
        logic [24:0] pix;
        logic [9:0]  status;
    } exp_t;

    exp_t sb[$];
    bit   probe_v = 1'b0;
    exp_t mon_e;

    always @(posedge clk) begin
        if (probe_v) begin
            #2;
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd0, 32'd1);
            end else begin
                mon_e = sb.pop_front();
                check("pix", {7'd0, ovl, r, g, b}, {7'd0, mon_e.pix});
                check("status", {22'd0, state, score_l, score_r}, {22'd0, mon_e.status});
            end
        end
    end

    task automatic probe(input int px, input int py, input bit bl);
        exp_t e;
        if (px < 0) px = 0;
        if (px > H_RES - 1) px = H_RES - 1;
        if (py < 0) py = 0;
        if (py > V_RES - 1) py = V_RES - 1;
        @(negedge clk);
        x = px[9:0];
        y = py[9:0];
        blank_n = bl;
        e.pix = model_pix(px, py, bl);
        e.status = {m_state[1:0], m_sl[SCORE_W-1:0], m_sr[SCORE_W-1:0]};
        sb.push_back(e);
        probe_v = 1'b1;
    endtask

    task automatic frame(input bit [1:0] u, input bit [1:0] d, input bit s);
        @(negedge clk);
        probe_v = 1'b0;
        vs = 1'b0;
        up = u;
        dn = d;
        serve = s;
        @(negedge clk);
        vs = 1'b1;
        #1 check("frame_tick", {31'd0, tick}, 32'd1);
        @(posedge clk);
        model_tick(u, d, s);
        #1 check("tick_single", {31'd0, tick}, 32'd0);
    endtask

    task automatic probe_scene();
        probe(m_bx, m_by, 1'b1);
        probe(m_bx - 1, m_by + BS - 1, 1'b1);
        probe(PAD_L_X + int'($urandom_range(0, PAD_W - 1)), m_pl - 1 + int'($urandom_range(0, 1)), 1'b1);
        probe(PAD_R_X + int'($urandom_range(0, PAD_W - 1)), m_pr + PAD_H - 1 + int'($urandom_range(0, 1)), 1'b1);
        probe(int'($urandom_range(0, H_RES - 1)), int'($urandom_range(0, V_RES - 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic check_reset_outputs();
        check("rst_state", {30'd0, state}, 32'd0);
        check("rst_scores", {24'd0, score_l, score_r}, 32'd0);
        check("rst_overlay", {7'd0, ovl, r, g, b}, 32'd0);
        check("rst_tick", {31'd0, tick}, 32'd0);
    endtask

    initial begin
        bit did_reset;
        did_reset = 1'b0;
        model_reset();
        #1 check_reset_outputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        probe(PAD_L_X, 220, 1'b1);
        probe(PAD_L_X, 219, 1'b1);
        probe(PAD_R_X + PAD_W - 1, 259, 1'b1);
        probe(316, 236, 1'b1);
        probe(319, 0, 1'b1);
        probe(316, 236, 1'b0);

        for (int i = 0; i < 10; i++) frame(2'b01, 2'b01, 1'b0);
        probe(PAD_L_X, 220, 1'b1);
        probe(PAD_L_X, 219, 1'b1);
        for (int i = 0; i < 100; i++) frame(2'b01, 2'b00, 1'b0);
        probe(PAD_L_X, 10, 1'b1);
        probe(PAD_L_X, 9, 1'b1);
        probe(PAD_L_X, 49, 1'b1);
        probe(PAD_L_X, 50, 1'b1);

        for (int f = 0; f < 7000 && m_state != 3; f++) begin
            frame(2'($urandom), 2'($urandom), ($urandom_range(0, 3) == 0));
            probe_scene();
            if (!did_reset && m_state == 1 && m_sl + m_sr >= 3) begin
                did_reset = 1'b1;
                @(negedge clk);
                probe_v = 1'b0;
                #2 rst_n = 1'b0;
                #1 check_reset_outputs();
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
                probe_scene();
            end
        end
        check("over_reached", m_state, 32'd3);
        probe(m_bx, m_by, 1'b1);

        frame(2'b00, 2'b00, 1'b1);
        probe(320, 0, 1'b1);
        probe(319, 8, 1'b1);
        probe(321, 0, 1'b1);
        probe(316, 236, 1'b1);

        @(negedge clk);
        probe_v = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("sb_drain", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
